// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   PORT_A / PORT_B         : port indices used by the picker and the tag pipeline
//   tag_t                   : per-command read tag {valid, port}
package ram_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;  // an accepted read occupies this stage
    logic port;   // port that issued the read
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker.
//   clk    in  system clock
//   rst    in  synchronous active-high reset (pointer -> PORT_A, gnt forced 0)
//   req    in  [1:0] request per port (bit 0 = A, bit 1 = B)
//   accept in  a granted request was taken at this edge
//   gnt    out [1:0] one-hot (or zero) grant, combinational from req and pointer
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_reg;
  logic ptr_next;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_reg == PORT_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a transfer the other port gets priority.
  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = gnt[0] ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= PORT_A;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one single-port RAM between ports A and B.
//   clk, rst                       : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      : port A command (held until a_gnt)
//   a_gnt                          : port A command accepted (combinational)
//   a_rvalid/a_rdata               : port A read return, 1+RD_LAT cycles after accept
//   b_*                            : same for port B
//   ram_addr/ram_data/ram_we       : registered command to the RAM
//   ram_q                          : RAM read data, valid RD_LAT cycles after addr is sampled
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  logic [1:0]        req_vec;
  logic [1:0]        gnt_vec;
  logic              accept;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_vec = {b_req, a_req};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (gnt_vec)
  );

  assign a_gnt  = gnt_vec[0];
  assign b_gnt  = gnt_vec[1];
  assign accept = |(req_vec & gnt_vec);

  always_comb begin
    sel_port  = gnt_vec[1] ? PORT_B : PORT_A;
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (sel_port == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // Command register: ram_we is a one-cycle strobe per accepted write;
  // address and data hold through idle cycles.
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_data_reg;
  logic              ram_we_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
      ram_we_reg   <= 1'b0;
    end else begin
      ram_we_reg <= accept & sel_we;
      if (accept) begin
        ram_addr_reg <= sel_addr;
        ram_data_reg <= sel_wdata;
      end
    end
  end

  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;
  assign ram_we   = ram_we_reg;

  // Tag pipeline: stage 0 loads at the accept edge, stage RD_LAT lines up
  // with ram_q being valid, so the return register fires 1+RD_LAT edges
  // after the accept.
  tag_t tag_in;
  tag_t tag_reg [0:RD_LAT];
  tag_t tag_out;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept & ~sel_we;
    tag_in.port  = sel_port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_reg[i] <= '0;
      end
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  assign tag_out = tag_reg[RD_LAT];

  // Return demux: one register pair per port; rdata holds between returns.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              rvalid_reg;
      logic [DATA_W-1:0] rdata_reg;
      logic              hit;

      assign hit = tag_out.valid && (tag_out.port == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= hit;
          if (hit) begin
            rdata_reg <= ram_q;
          end
        end
      end
    end
  endgenerate

  assign a_rvalid = g_port[0].rvalid_reg;
  assign a_rdata  = g_port[0].rdata_reg;
  assign b_rvalid = g_port[1].rvalid_reg;
  assign b_rdata  = g_port[1].rdata_reg;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed bench. Two arbiters (RD_LAT=1 and RD_LAT=3)
// share the same stimulus, each with its own behavioural write-first RAM.
module tb_ram_rr_arbiter;

  logic       clk_tb = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, ram_we1;
  logic [7:0] a_rdata1, b_rdata1, ram_data1, ram_q1;
  logic [4:0] ram_addr1;
  logic       a_gnt3, a_rvalid3, b_gnt3, b_rvalid3, ram_we3;
  logic [7:0] a_rdata3, b_rdata3, ram_data3, ram_q3;
  logic [4:0] ram_addr3;

  int checks = 0;
  int errors = 0;

  always #5 clk_tb = ~clk_tb;

  ram_rr_arbiter #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) dut1 (
    .clk(clk_tb), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_we(ram_we1), .ram_q(ram_q1)
  );

  ram_rr_arbiter #(.DATA_W(8), .ADDR_W(5), .RD_LAT(3)) dut3 (
    .clk(clk_tb), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
    .ram_addr(ram_addr3), .ram_data(ram_data3), .ram_we(ram_we3), .ram_q(ram_q3)
  );

  // Write-first RAM models; q is valid RD_LAT edges after addr is sampled.
  logic [7:0] mem1 [0:31];
  logic [7:0] mem3 [0:31];
  logic [7:0] p3_0, p3_1;

  always @(posedge clk_tb) begin
    if (ram_we1) mem1[ram_addr1] <= ram_data1;
    ram_q1 <= ram_we1 ? ram_data1 : mem1[ram_addr1];
  end

  always @(posedge clk_tb) begin
    if (ram_we3) mem3[ram_addr3] <= ram_data3;
    p3_0   <= ram_we3 ? ram_data3 : mem3[ram_addr3];
    p3_1   <= p3_0;
    ram_q3 <= p3_1;
  end

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 5'd0; b_addr = 5'd0; a_wdata = 8'h00; b_wdata = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (a_gnt1 !== 1'b0 || b_gnt1 !== 1'b0) begin
        errors++; $display("FAIL reset_gnt cyc %0d: got a=%b b=%b expected 0 0", c, a_gnt1, b_gnt1);
      end
      checks++;
      if (ram_we1 !== 1'b0 || a_rvalid1 !== 1'b0 || b_rvalid1 !== 1'b0) begin
        errors++; $display("FAIL reset_out cyc %0d: got we=%b arv=%b brv=%b expected 0 0 0", c, ram_we1, a_rvalid1, b_rvalid1);
      end
    end
    checks++;
    if (ram_addr1 !== 5'd0 || ram_data1 !== 8'h00 || a_rdata1 !== 8'h00 || b_rdata1 !== 8'h00) begin
      errors++; $display("FAIL reset_regs: got addr=%h data=%h ard=%h brd=%h expected all 0", ram_addr1, ram_data1, a_rdata1, b_rdata1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_gnt1 !== 1'b1 || b_gnt1 !== 1'b0) begin
      errors++; $display("FAIL reset_release_ptr: got a=%b b=%b expected 1 0", a_gnt1, b_gnt1);
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
  endtask

  task automatic test_write_sweep();
    a_req = 1'b1; a_we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_addr = 5'(i); a_wdata = 8'(8'hA0 + i);
      #1;
      checks++;
      if (a_gnt1 !== 1'b1 || b_gnt1 !== 1'b0) begin
        errors++; $display("FAIL sweep_gnt %0d: got a=%b b=%b expected 1 0", i, a_gnt1, b_gnt1);
      end
      step();
      checks++;
      if (ram_we1 !== 1'b1 || ram_addr1 !== 5'(i) || ram_data1 !== 8'(8'hA0 + i)) begin
        errors++; $display("FAIL sweep_cmd %0d: got we=%b addr=%0d data=%h expected 1 %0d %h", i, ram_we1, ram_addr1, ram_data1, i, 8'(8'hA0 + i));
      end
    end
    a_req = 1'b0; a_we = 1'b0;
    step();
    checks++;
    if (ram_we1 !== 1'b0 || ram_addr1 !== 5'd31 || ram_data1 !== 8'hBF) begin
      errors++; $display("FAIL sweep_idle: got we=%b addr=%0d data=%h expected 0 31 bf", ram_we1, ram_addr1, ram_data1);
    end
  endtask

  task automatic test_alternate_reads();
    logic ea1, eb1, ea3, eb3;
    // Reset puts the pointer back on A so the sequence starts A,B,...
    rst = 1'b1; step(); rst = 1'b0;
    a_we = 1'b0; b_we = 1'b0; a_addr = 5'd5; b_addr = 5'd9;
    for (int c = 0; c < 10; c++) begin
      a_req = (c < 6); b_req = (c < 6);
      #1;
      if (c < 6) begin
        checks++;
        if (a_gnt1 !== (c % 2 == 0) || b_gnt1 !== (c % 2 == 1)) begin
          errors++; $display("FAIL alt_gnt cyc %0d: got a=%b b=%b expected a=%b", c, a_gnt1, b_gnt1, (c % 2 == 0));
        end
      end
      step();
      ea1 = (c >= 2 && c <= 7 && c % 2 == 0);
      eb1 = (c >= 2 && c <= 7 && c % 2 == 1);
      ea3 = (c >= 4 && c <= 9 && c % 2 == 0);
      eb3 = (c >= 4 && c <= 9 && c % 2 == 1);
      checks++;
      if (a_rvalid1 !== ea1 || b_rvalid1 !== eb1) begin
        errors++; $display("FAIL alt_rvalid_lat1 cyc %0d: got a=%b b=%b expected a=%b b=%b", c, a_rvalid1, b_rvalid1, ea1, eb1);
      end
      checks++;
      if ((ea1 && a_rdata1 !== 8'hA5) || (eb1 && b_rdata1 !== 8'hA9)) begin
        errors++; $display("FAIL alt_rdata_lat1 cyc %0d: got a=%h b=%h expected a5/a9", c, a_rdata1, b_rdata1);
      end
      checks++;
      if (a_rvalid3 !== ea3 || b_rvalid3 !== eb3) begin
        errors++; $display("FAIL alt_rvalid_lat3 cyc %0d: got a=%b b=%b expected a=%b b=%b", c, a_rvalid3, b_rvalid3, ea3, eb3);
      end
      checks++;
      if ((ea3 && a_rdata3 !== 8'hA5) || (eb3 && b_rdata3 !== 8'hA9)) begin
        errors++; $display("FAIL alt_rdata_lat3 cyc %0d: got a=%h b=%h expected a5/a9", c, a_rdata3, b_rdata3);
      end
    end
    checks++;
    if (a_rdata1 !== 8'hA5 || b_rdata1 !== 8'hA9) begin
      errors++; $display("FAIL alt_rdata_hold: got a=%h b=%h expected a5 a9", a_rdata1, b_rdata1);
    end
  endtask

  task automatic test_write_then_read();
    // E0: B writes 3c to 31
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 5'd31; b_wdata = 8'h3C;
    #1;
    checks++;
    if (b_gnt1 !== 1'b1 || a_gnt1 !== 1'b0) begin
      errors++; $display("FAIL wr_gnt_b: got a=%b b=%b expected 0 1", a_gnt1, b_gnt1);
    end
    step();
    // E1: A reads 31
    b_req = 1'b0; b_we = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 5'd31;
    #1;
    checks++;
    if (a_gnt1 !== 1'b1) begin
      errors++; $display("FAIL rd_gnt_a: got %b expected 1", a_gnt1);
    end
    step();
    checks++;
    if (ram_addr1 !== 5'd31 || ram_we1 !== 1'b0) begin
      errors++; $display("FAIL rd_cmd31: got addr=%0d we=%b expected 31 0", ram_addr1, ram_we1);
    end
    // E2: A reads 0 (wrap after 31)
    a_addr = 5'd0;
    step();
    checks++;
    if (ram_addr1 !== 5'd0 || b_rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd_cmd0: got addr=%0d brv=%b expected 0 0", ram_addr1, b_rvalid1);
    end
    a_req = 1'b0;
    step(); // E3
    checks++;
    if (a_rvalid1 !== 1'b1 || a_rdata1 !== 8'h3C) begin
      errors++; $display("FAIL raw_data: got rv=%b data=%h expected 1 3c", a_rvalid1, a_rdata1);
    end
    step(); // E4
    checks++;
    if (a_rvalid1 !== 1'b1 || a_rdata1 !== 8'hA0) begin
      errors++; $display("FAIL wrap_data: got rv=%b data=%h expected 1 a0", a_rvalid1, a_rdata1);
    end
    step(); // E5
    checks++;
    if (a_rvalid1 !== 1'b0 || a_rdata1 !== 8'hA0) begin
      errors++; $display("FAIL wrap_after: got rv=%b data=%h expected 0 a0", a_rvalid1, a_rdata1);
    end
  endtask

  task automatic test_reset_midflight();
    // Pointer is on B here (last accepts were A reads).
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = 5'd5; b_addr = 5'd9;
    #1;
    checks++;
    if (b_gnt1 !== 1'b1 || a_gnt1 !== 1'b0) begin
      errors++; $display("FAIL mid_gnt0: got a=%b b=%b expected 0 1", a_gnt1, b_gnt1);
    end
    step();
    checks++;
    if (a_gnt1 !== 1'b1 || b_gnt1 !== 1'b0) begin
      errors++; $display("FAIL mid_gnt1: got a=%b b=%b expected 1 0", a_gnt1, b_gnt1);
    end
    step();
    // Reset edge with a write still requested: must not be accepted.
    rst = 1'b1; b_req = 1'b0; a_we = 1'b1; a_wdata = 8'h55;
    #1;
    checks++;
    if (a_gnt1 !== 1'b0) begin
      errors++; $display("FAIL mid_gnt_rst: got %b expected 0", a_gnt1);
    end
    step();
    checks++;
    if (ram_we1 !== 1'b0 || a_rvalid1 !== 1'b0 || b_rvalid1 !== 1'b0 || a_rdata1 !== 8'h00 || b_rdata1 !== 8'h00) begin
      errors++; $display("FAIL mid_rst_edge: got we=%b arv=%b brv=%b ard=%h brd=%h expected 0 0 0 00 00", ram_we1, a_rvalid1, b_rvalid1, a_rdata1, b_rdata1);
    end
    rst = 1'b0; a_req = 1'b0; a_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (a_rvalid1 !== 1'b0 || b_rvalid1 !== 1'b0 || a_rvalid3 !== 1'b0 || b_rvalid3 !== 1'b0 || ram_we1 !== 1'b0) begin
        errors++; $display("FAIL mid_no_return cyc %0d: got rv1=%b%b rv3=%b%b we=%b expected all 0", c, a_rvalid1, b_rvalid1, a_rvalid3, b_rvalid3, ram_we1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_alternate_reads();
    test_write_then_read();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
